// File: rtl/xnor_match_accumulator.sv
// rtl/xnor_match_accumulator.sv - per-frame XNOR match score and full-byte hit accumulator
// Optional feature macro: BYTE_MASK_EN (adds mask_in and a mask register loaded with the key)
module xnor_match_accumulator #(
  parameter int FRAME_LEN = 8,
  parameter int SCORE_W   = 7,
  parameter int HIT_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_load,
  input  logic [7:0]         key_in,
`ifdef BYTE_MASK_EN
  input  logic [7:0]         mask_in,
`endif
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SCORE_W-1:0] out_score,
  output logic [HIT_W-1:0]   out_hits,
  output logic               busy
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [0:0] {ACCUM, DONE} state_t;

  state_t             state_q;
  logic [7:0]         key_q;
  logic [CNT_W-1:0]   byte_cnt_q;
  logic [SCORE_W-1:0] score_acc_q, score_acc_d;
  logic [HIT_W-1:0]   hit_acc_q, hit_acc_d;
  logic [SCORE_W-1:0] out_score_q;
  logic [HIT_W-1:0]   out_hits_q;
  logic               out_valid_q;

  logic [7:0]         eq;
  logic [3:0]         eq_pop;
  logic               eq_hit;
  logic               accept;
  logic               last_byte;

`ifdef BYTE_MASK_EN
  logic [7:0]         mask_q;

  // Mask register shares the key's load strobe; masked bits always read as matching
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mask_q <= 8'h00;
    else if (key_load) mask_q <= mask_in;
  end
`endif

  // Key register; a byte accepted alongside key_load still sees the old key
  always_ff @(posedge clk or posedge reset) begin
    if (reset) key_q <= 8'h00;
    else if (key_load) key_q <= key_in;
  end

  // Per-byte equality vector, its popcount and the next accumulator values
  always_comb begin
`ifdef BYTE_MASK_EN
    eq = ~(in_data ^ key_q) | mask_q;
`else
    eq = ~(in_data ^ key_q);
`endif
    eq_pop = 4'd0;
    for (int i = 0; i < 8; i++) begin
      eq_pop = eq_pop + {3'd0, eq[i]};
    end
    eq_hit      = (eq == 8'hFF);
    accept      = in_valid && (state_q == ACCUM);
    last_byte   = (byte_cnt_q == CNT_W'(FRAME_LEN - 1));
    score_acc_d = score_acc_q + SCORE_W'(eq_pop);
    hit_acc_d   = hit_acc_q + HIT_W'(eq_hit);
  end

  // Frame FSM: accumulate bytes in ACCUM, present the registered result in DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ACCUM;
      byte_cnt_q  <= '0;
      score_acc_q <= '0;
      hit_acc_q   <= '0;
      out_score_q <= '0;
      out_hits_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (last_byte) begin
              out_score_q <= score_acc_d;
              out_hits_q  <= hit_acc_d;
              out_valid_q <= 1'b1;
              byte_cnt_q  <= '0;
              score_acc_q <= '0;
              hit_acc_q   <= '0;
              state_q     <= DONE;
            end else begin
              byte_cnt_q  <= byte_cnt_q + CNT_W'(1);
              score_acc_q <= score_acc_d;
              hit_acc_q   <= hit_acc_d;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_score = out_score_q;
  assign out_hits  = out_hits_q;
  assign busy      = (byte_cnt_q != '0);

endmodule

// File: tb/tb_xnor_match_accumulator.sv
// tb/tb_xnor_match_accumulator.sv - self-checking bench for xnor_match_accumulator
module tb_xnor_match_accumulator;

  localparam int FRAME_LEN = 8;
  localparam int SCORE_W   = 7;
  localparam int HIT_W     = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               key_load;
  logic [7:0]         key_in;
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [SCORE_W-1:0] out_score;
  logic [HIT_W-1:0]   out_hits;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: bytes of the open frame with the key each one saw
  logic [7:0] m_key;
  logic [7:0] m_bytes[$];
  logic [7:0] m_keys[$];
  logic       m_done;
  int         m_score;
  int         m_hits;

  xnor_match_accumulator #(
    .FRAME_LEN(FRAME_LEN),
    .SCORE_W  (SCORE_W),
    .HIT_W    (HIT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_load (key_load),
    .key_in   (key_in),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_score(out_score),
    .out_hits (out_hits),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and advance the model; outputs are then sampled 1 ns after the edge
  task automatic step(input logic v, input logic [7:0] d, input logic ordy,
                      input logic kl, input logic [7:0] kin);
    logic nd;
    logic [7:0] diff;
    nd = m_done;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    key_load  = kl;
    key_in    = kin;
    if (!m_done && v) begin
      m_bytes.push_back(d);
      m_keys.push_back(m_key);
      if (m_bytes.size() == FRAME_LEN) begin
        m_score = 0;
        m_hits  = 0;
        for (int i = 0; i < FRAME_LEN; i++) begin
          diff = m_bytes[i] ^ m_keys[i];
          m_score += 8 - $countones(diff);
          if (diff == 8'h00) m_hits++;
        end
        m_bytes.delete();
        m_keys.delete();
        nd = 1'b1;
      end
    end else if (m_done && ordy) begin
      nd = 1'b0;
    end
    if (kl) m_key = kin;
    @(posedge clk);
    #1;
    m_done = nd;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    key_load  = 1'b0;
    key_in    = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    m_key = 8'h00;
    m_bytes.delete();
    m_keys.delete();
    m_done = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_score !== '0) begin failures++; $display("FAIL reset_out_score got=%0d exp=0", out_score); end
    checks++; if (out_hits !== '0) begin failures++; $display("FAIL reset_out_hits got=%0d exp=0", out_hits); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_all_match();
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < FRAME_LEN; i++) begin
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL all_match_early_valid byte=%0d got=%0b exp=0", i, out_valid); end
      step(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL all_match_valid got=%0b exp=1", out_valid); end
    checks++; if (out_score !== SCORE_W'(64)) begin failures++; $display("FAIL all_match_score got=%0d exp=64", out_score); end
    checks++; if (out_hits !== HIT_W'(8)) begin failures++; $display("FAIL all_match_hits got=%0d exp=8", out_hits); end
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL all_match_release got=%0b exp=0", out_valid); end
  endtask

  task automatic test_no_match();
    for (int i = 0; i < FRAME_LEN; i++) step(1'b1, 8'h5A, 1'b0, 1'b0, 8'h00);
    checks++; if (out_score !== SCORE_W'(0)) begin failures++; $display("FAIL no_match_score got=%0d exp=0", out_score); end
    checks++; if (out_hits !== HIT_W'(0)) begin failures++; $display("FAIL no_match_hits got=%0d exp=0", out_hits); end
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_mixed();
    logic [7:0] pat [8];
    pat = '{8'h0F, 8'hFF, 8'h00, 8'hFF, 8'h01, 8'hFF, 8'hFF, 8'h80};
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < FRAME_LEN; i++) step(1'b1, pat[i], 1'b0, 1'b0, 8'h00);
    checks++; if (out_score !== SCORE_W'(38)) begin failures++; $display("FAIL mixed_score got=%0d exp=38", out_score); end
    checks++; if (out_hits !== HIT_W'(4)) begin failures++; $display("FAIL mixed_hits got=%0d exp=4", out_hits); end
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_backpressure();
    logic [SCORE_W-1:0] s0;
    logic [HIT_W-1:0]   h0;
    for (int i = 0; i < FRAME_LEN; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 8'h00);
    s0 = out_score;
    h0 = out_hits;
    checks++; if (s0 !== SCORE_W'(m_score)) begin failures++; $display("FAIL bp_score got=%0d exp=%0d", s0, m_score); end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0, 8'h00);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold cyc=%0d valid=%0b ready=%0b exp valid=1 ready=0", i, out_valid, in_ready); end
      checks++; if (out_score !== s0 || out_hits !== h0) begin failures++; $display("FAIL bp_stable cyc=%0d score=%0d hits=%0d exp %0d %0d", i, out_score, out_hits, s0, h0); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_consumed cyc=%0d busy=%0b exp=0", i, busy); end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release valid=%0b ready=%0b exp valid=0 ready=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 3; i++) step(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midframe_busy got=%0b exp=1", busy); end
    do_reset();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_score !== '0 || out_hits !== '0 || in_ready !== 1'b1)
      begin failures++; $display("FAIL midframe_reset busy=%0b valid=%0b score=%0d hits=%0d ready=%0b", busy, out_valid, out_score, out_hits, in_ready); end
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < FRAME_LEN; i++) step(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
    checks++; if (out_valid !== 1'b1 || out_score !== SCORE_W'(64) || out_hits !== HIT_W'(8))
      begin failures++; $display("FAIL midframe_next valid=%0b score=%0d hits=%0d exp 1 64 8", out_valid, out_score, out_hits); end
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_key_load_same_cycle();
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5);
    step(1'b1, 8'hA5, 1'b0, 1'b1, 8'h00);
    for (int i = 1; i < FRAME_LEN; i++) step(1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++; if (out_score !== SCORE_W'(64) || out_hits !== HIT_W'(8))
      begin failures++; $display("FAIL keyload_same_cycle score=%0d hits=%0d exp 64 8", out_score, out_hits); end
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    logic v, ordy, kl;
    logic [7:0] d, kin;
    for (int c = 0; c < 400; c++) begin
      v    = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 1) == 1);
      kl   = ($urandom_range(0, 15) == 0);
      kin  = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'hA5;
      d    = ($urandom_range(0, 2) == 0) ? m_key : 8'($urandom);
      step(v, d, ordy, kl, kin);
      checks++; if (out_valid !== m_done || in_ready !== !m_done || busy !== (m_bytes.size() != 0))
        begin failures++; $display("FAIL random_ctrl cyc=%0d valid=%0b ready=%0b busy=%0b exp valid=%0b busy=%0b", c, out_valid, in_ready, busy, m_done, m_bytes.size() != 0); end
      if (m_done) begin
        checks++; if (out_score !== SCORE_W'(m_score) || out_hits !== HIT_W'(m_hits))
          begin failures++; $display("FAIL random_result cyc=%0d score=%0d hits=%0d exp %0d %0d", c, out_score, out_hits, m_score, m_hits); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    m_key = 8'h00;
    m_done = 1'b0;
    m_score = 0;
    m_hits = 0;
    test_reset();
    test_all_match();
    test_no_match();
    test_mixed();
    test_backpressure();
    test_reset_midframe();
    test_key_load_same_cycle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
